// File: rtl/rf_pkg.sv
// Shared constants and state encoding for the multi-port integer register file.
package rf_pkg;

  localparam int unsigned RF_XLEN_DEF   = 32;
  localparam int unsigned RF_NREG_RV32I = 32;
  localparam int unsigned RF_NREG_RV32E = 16;
  localparam int unsigned RF_NREG_DEF   = RF_NREG_RV32I;
  localparam int unsigned RF_X0         = 0;

  typedef enum logic {
    RF_SCRUB,
    RF_RUN
  } rf_state_e;

endpackage

// File: rtl/rf_scrub_ctrl.sv
// Post-reset scrub sequencer: walks x1..x(NREG-1) writing zero, then raises ready.
module rf_scrub_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned NREG = RF_NREG_DEF,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          ready_o,
  output logic          scrub_we_o,
  output logic [AW-1:0] scrub_addr_o
);

  rf_state_e     state_q;
  logic [AW-1:0] cnt_q;
  logic          ready_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RF_SCRUB;
      cnt_q   <= AW'(1);
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        RF_SCRUB: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(NREG - 1)) begin
            state_q <= RF_RUN;
            ready_q <= 1'b1;
          end
        end
        RF_RUN: begin
          state_q <= RF_RUN;
        end
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign scrub_we_o   = (state_q == RF_SCRUB);
  assign scrub_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised N-read/1-write integer register file with write-through bypass and hardwired x0.
// Optional RF_SCOREBOARD_EN adds per-register pending bits and per-port busy flags.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN_DEF,
  parameter int unsigned NREG = RF_NREG_DEF,
  parameter int unsigned NRD  = 2,
  parameter int unsigned AW   = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RST,
  output logic                rf_ready,
  input  logic                rd_wen,
  input  logic [AW-1:0]       rd,
  input  logic [XLEN-1:0]     rd_data,
  input  logic [NRD-1:0]      rs_ren,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data
`ifdef RF_SCOREBOARD_EN
  ,
  input  logic                alloc_en,
  input  logic [AW-1:0]       alloc_rd,
  output logic [NRD-1:0]      rs_busy
`endif
);

  localparam logic [AW-1:0] X0 = AW'(RF_X0);

  logic            run;
  logic            scrub_we;
  logic [AW-1:0]   scrub_addr;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] mem_q [NREG];

  rf_scrub_ctrl #(
    .NREG (NREG),
    .AW   (AW)
  ) u_scrub (
    .clk_i        (CLK),
    .rst_i        (RST),
    .ready_o      (run),
    .scrub_we_o   (scrub_we),
    .scrub_addr_o (scrub_addr)
  );

  assign rf_ready = run;

  // Scrub owns the write port until ready; the array itself carries no reset.
  assign wr_en   = !RST && (scrub_we || (run && rd_wen && (rd != X0)));
  assign wr_addr = scrub_we ? scrub_addr : rd;
  assign wr_data = scrub_we ? '0 : rd_data;

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Set is applied after clear so a new allocation wins over a retiring write.
  always_comb begin
    pend_d = pend_q;
    if (!run) begin
      pend_d = '0;
    end else begin
      if (rd_wen && (rd != X0)) pend_d[rd] = 1'b0;
      if (alloc_en && (alloc_rd != X0)) pend_d[alloc_rd] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) pend_q <= '0;
    else     pend_q <= pend_d;
  end
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] sel;
    logic [XLEN-1:0] data_d;
    logic [XLEN-1:0] data_q;

    assign addr = rs_addr[i*AW +: AW];

    always_comb begin
      sel = mem_q[addr];
      if (addr == X0) begin
        sel = '0;
      end else if (rd_wen && (rd == addr)) begin
        sel = rd_data;
      end
    end

    always_comb begin
      data_d = data_q;
      if (!run) begin
        data_d = '0;
      end else if (rs_ren[i]) begin
        data_d = sel;
      end
    end

    always_ff @(posedge CLK) begin
      if (RST) data_q <= '0;
      else     data_q <= data_d;
    end

    assign rs_data[i*XLEN +: XLEN] = data_q;

`ifdef RF_SCOREBOARD_EN
    assign rs_busy[i] = run && !RST && pend_q[addr] && !(rd_wen && (rd == addr));
`endif
  end

endmodule
